// File: rtl/fpnew_pkg.sv
// Shared FPU types. The status flags travel with every result through the reorder buffer.
package fpnew_pkg;

  typedef struct packed {
    logic NV;  // invalid
    logic DZ;  // divide by zero
    logic OF;  // overflow
    logic UF;  // underflow
    logic NX;  // inexact
  } status_t;

endpackage

// File: rtl/fpnew_rob_wr_sel.sv
// Completion-port select for one ROB entry: the lowest matching port index wins,
// and any further match on this entry in the same cycle raises dup.
module fpnew_rob_wr_sel
  import fpnew_pkg::*;
#(
  parameter int unsigned NumOpGroups = 4,
  parameter int unsigned Width       = 64,
  parameter int unsigned IdWidth     = 3,
  parameter int unsigned Entry       = 0
) (
  input  logic [NumOpGroups-1:0]              cpl_valid,
  input  logic [NumOpGroups-1:0][IdWidth-1:0] cpl_id,
  input  logic [NumOpGroups-1:0][Width-1:0]   cpl_result,
  input  status_t [NumOpGroups-1:0]           cpl_status,
  output logic                                wr_en,
  output logic [Width-1:0]                    wr_result,
  output status_t                             wr_status,
  output logic                                dup
);

  // Scan from the highest port down so the lowest index is written last.
  always_comb begin
    wr_en     = 1'b0;
    wr_result = '0;
    wr_status = '0;
    dup       = 1'b0;
    for (int p = NumOpGroups - 1; p >= 0; p--) begin
      if (cpl_valid[p] && cpl_id[p] == IdWidth'(Entry)) begin
        if (wr_en) dup = 1'b1;
        wr_en     = 1'b1;
        wr_result = cpl_result[p];
        wr_status = cpl_status[p];
      end
    end
  end

endmodule

// File: rtl/fpnew_result_reorder.sv
// Circular reorder buffer: opgroups complete out of order by slot id, and results
// are released strictly in issue order from the head entry.
module fpnew_result_reorder
  import fpnew_pkg::*;
#(
  parameter int unsigned NumOpGroups = 4,
  parameter int unsigned Depth       = 8,
  parameter int unsigned Width       = 64,
  parameter int unsigned TagWidth    = 1,
  localparam int unsigned IdWidth    = $clog2(Depth)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic                                issue_valid_i,
  input  logic [TagWidth-1:0]                 issue_tag_i,
  output logic                                issue_ready_o,
  output logic [IdWidth-1:0]                  issue_id_o,
  input  logic [NumOpGroups-1:0]              cpl_valid_i,
  output logic [NumOpGroups-1:0]              cpl_ready_o,
  input  logic [NumOpGroups-1:0][IdWidth-1:0] cpl_id_i,
  input  logic [NumOpGroups-1:0][Width-1:0]   cpl_result_i,
  input  status_t [NumOpGroups-1:0]           cpl_status_i,
  output logic [Width-1:0]                    result_o,
  output status_t                             status_o,
  output logic [TagWidth-1:0]                 tag_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic                                busy_o,
  output logic                                err_o
);

  typedef struct packed {
    logic                alloc;
    logic                done;
    logic [Width-1:0]    result;
    status_t             status;
    logic [TagWidth-1:0] tag;
  } rob_entry_t;

  rob_entry_t [Depth-1:0] rob_q;
  logic [IdWidth-1:0]     head_q, tail_q;
  logic [IdWidth:0]       count_q;
  logic                   err_q;

  logic [Depth-1:0]            wr_en, wr_dup;
  logic [Depth-1:0][Width-1:0] wr_result;
  status_t [Depth-1:0]         wr_status;
  logic                        issue_hs, pop, err_set;

  for (genvar e = 0; e < Depth; e++) begin : g_sel
    fpnew_rob_wr_sel #(
      .NumOpGroups(NumOpGroups),
      .Width      (Width),
      .IdWidth    (IdWidth),
      .Entry      (e)
    ) u_sel (
      .cpl_valid (cpl_valid_i),
      .cpl_id    (cpl_id_i),
      .cpl_result(cpl_result_i),
      .cpl_status(cpl_status_i),
      .wr_en     (wr_en[e]),
      .wr_result (wr_result[e]),
      .wr_status (wr_status[e]),
      .dup       (wr_dup[e])
    );
  end

  assign issue_ready_o = (count_q != (IdWidth+1)'(Depth));
  assign issue_id_o    = tail_q;
  assign issue_hs      = issue_valid_i & issue_ready_o;
  assign cpl_ready_o   = '1;

  assign out_valid_o = rob_q[head_q].alloc & rob_q[head_q].done;
  assign result_o    = rob_q[head_q].result;
  assign status_o    = rob_q[head_q].status;
  assign tag_o       = rob_q[head_q].tag;
  assign pop         = out_valid_o & out_ready_i;
  assign busy_o      = (count_q != '0);
  assign err_o       = err_q;

  // A completion is illegal if it targets a free slot or the head being retired.
  always_comb begin
    err_set = |wr_dup;
    for (int p = 0; p < NumOpGroups; p++) begin
      if (cpl_valid_i[p] &&
          (!rob_q[cpl_id_i[p]].alloc || (pop && cpl_id_i[p] == head_q)))
        err_set = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < Depth; e++) begin
        rob_q[e].alloc <= 1'b0;
        rob_q[e].done  <= 1'b0;
      end
    end else begin
      if (issue_hs) tail_q <= tail_q + 1'b1;
      if (pop)      head_q <= head_q + 1'b1;
      count_q <= count_q + (IdWidth+1)'(issue_hs) - (IdWidth+1)'(pop);
      // Issue only hits a free slot and writes only hit allocated ones, so these never collide.
      for (int e = 0; e < Depth; e++) begin
        if (issue_hs && tail_q == IdWidth'(e)) begin
          rob_q[e].alloc <= 1'b1;
          rob_q[e].done  <= 1'b0;
          rob_q[e].tag   <= issue_tag_i;
        end else if (pop && head_q == IdWidth'(e)) begin
          rob_q[e].alloc <= 1'b0;
          rob_q[e].done  <= 1'b0;
        end else if (wr_en[e] && rob_q[e].alloc) begin
          rob_q[e].result <= wr_result[e];
          rob_q[e].status <= wr_status[e];
          rob_q[e].done   <= 1'b1;
        end
      end
    end
  end

  // Sticky until reset; a flush leaves it alone so late stale completions stay visible.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)      err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

endmodule

// File: tb/tb_fpnew_result_reorder.sv
// Bench for the in-order completion ROB: issue-order scoreboard checked on every pop,
// a table of single-op round trips, and directed multi-cycle corner sequences.
module tb_fpnew_result_reorder;
  import fpnew_pkg::*;

  localparam int unsigned NOG = 4, DEPTH = 8, W = 64, TW = 4, IDW = 3;

  logic                        clk_i = 1'b0;
  logic                        rst_ni, flush_i, issue_valid_i, out_ready_i;
  logic [TW-1:0]               issue_tag_i;
  logic                        issue_ready_o, out_valid_o, busy_o, err_o;
  logic [IDW-1:0]              issue_id_o;
  logic [NOG-1:0]              cpl_valid_i, cpl_ready_o;
  logic [NOG-1:0][IDW-1:0]     cpl_id_i;
  logic [NOG-1:0][W-1:0]       cpl_result_i;
  status_t [NOG-1:0]           cpl_status_i;
  logic [W-1:0]                result_o;
  status_t                     status_o;
  logic [TW-1:0]               tag_o;

  fpnew_result_reorder #(
    .NumOpGroups(NOG), .Depth(DEPTH), .Width(W), .TagWidth(TW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_tag_i(issue_tag_i),
    .issue_ready_o(issue_ready_o), .issue_id_o(issue_id_o),
    .cpl_valid_i(cpl_valid_i), .cpl_ready_o(cpl_ready_o), .cpl_id_i(cpl_id_i),
    .cpl_result_i(cpl_result_i), .cpl_status_i(cpl_status_i),
    .result_o(result_o), .status_o(status_o), .tag_o(tag_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [W-1:0]  result;
    status_t       status;
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct {
    logic [TW-1:0] tag;
    int            port;
    logic [W-1:0]  result;
    status_t       status;
  } vec_t;

  exp_t           sb[$];
  int             n_cmp = 0, n_bad = 0, n_pop = 0;
  logic [IDW-1:0] exp_tail = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Every retirement is checked against the oldest outstanding issue.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got result %0h want no output", result_o);
      end else begin
        e = sb.pop_front();
        chk("pop_result", result_o, e.result);
        chk("pop_status", 64'(status_o), 64'(e.status));
        chk("pop_tag", 64'(tag_o), 64'(e.tag));
      end
      n_pop++;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    sb.delete();
    exp_tail = '0;
  endtask

  task automatic issue(input logic [TW-1:0] tag, input logic [W-1:0] res, input status_t st);
    exp_t e;
    chk("issue_ready", 64'(issue_ready_o), 64'd1);
    chk("issue_id", 64'(issue_id_o), 64'(exp_tail));
    issue_valid_i = 1'b1;
    issue_tag_i   = tag;
    e.result = res; e.status = st; e.tag = tag;
    sb.push_back(e);
    exp_tail++;
    tick();
    issue_valid_i = 1'b0;
  endtask

  task automatic set_cpl(input int p, input logic [IDW-1:0] id, input logic [W-1:0] res,
                         input status_t st);
    cpl_valid_i[p]  = 1'b1;
    cpl_id_i[p]     = id;
    cpl_result_i[p] = res;
    cpl_status_i[p] = st;
  endtask

  task automatic wait_pops(input string name, input int target, input int budget);
    int c = 0;
    while (n_pop < target && c < budget) begin
      tick();
      c++;
    end
    chk(name, 64'(n_pop), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t           vecs[6];
    int             base;
    logic [IDW-1:0] id;
    logic [IDW-1:0] ids[4];

    rst_ni = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0; issue_tag_i = '0;
    out_ready_i = 1'b0; cpl_valid_i = '0; cpl_id_i = '0; cpl_result_i = '0; cpl_status_i = '0;

    // 1: reset state
    tick(); tick();
    chk("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_issue_id", 64'(issue_id_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    rst_ni = 1'b1;

    // 2: younger op completes first, release stays in issue order
    base = n_pop;
    out_ready_i = 1'b1;
    issue(4'hA, 64'h11, status_t'(5'h01));
    issue(4'hB, 64'h22, status_t'(5'h10));
    set_cpl(1, 3'd1, 64'h22, status_t'(5'h10));
    tick(); cpl_valid_i = '0;
    chk("t2_hold_younger", 64'(out_valid_o), 64'd0);
    set_cpl(0, 3'd0, 64'h11, status_t'(5'h01));
    tick(); cpl_valid_i = '0;
    chk("t2_head_valid", 64'(out_valid_o), 64'd1);
    chk("t2_head_result", result_o, 64'h11);
    wait_pops("t2_pops", base + 2, 10);
    chk("t2_idle", 64'(busy_o), 64'd0);

    // table: single-op round trips across ports, tags and flags
    vecs[0] = '{tag: 4'h1, port: 0, result: 64'hDEAD_BEEF_0000_0001, status: status_t'(5'h00)};
    vecs[1] = '{tag: 4'h2, port: 1, result: 64'h0123_4567_89AB_CDEF, status: status_t'(5'h1F)};
    vecs[2] = '{tag: 4'h3, port: 2, result: 64'hFFFF_FFFF_FFFF_FFFF, status: status_t'(5'h04)};
    vecs[3] = '{tag: 4'hF, port: 3, result: 64'h0, status: status_t'(5'h08)};
    vecs[4] = '{tag: 4'h0, port: 3, result: 64'h8000_0000_0000_0000, status: status_t'(5'h02)};
    vecs[5] = '{tag: 4'h7, port: 1, result: 64'h5555_AAAA_5555_AAAA, status: status_t'(5'h11)};
    out_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      id = exp_tail;
      issue(vecs[i].tag, vecs[i].result, vecs[i].status);
      set_cpl(vecs[i].port, id, vecs[i].result, vecs[i].status);
      tick(); cpl_valid_i = '0;
      chk("tbl_valid", 64'(out_valid_o), 64'd1);
      chk("tbl_result", result_o, vecs[i].result);
      chk("tbl_status", 64'(status_o), 64'(vecs[i].status));
      chk("tbl_tag", 64'(tag_o), 64'(vecs[i].tag));
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
    end

    // 3: fill, full blocks issue even while head pops, then wrap to id 0
    reset_dut();
    base = n_pop;
    for (int i = 0; i < 8; i++) issue(TW'(i), 64'h300 + 64'(i), status_t'(5'h00));
    chk("t3_full_ready", 64'(issue_ready_o), 64'd0);
    chk("t3_full_busy", 64'(busy_o), 64'd1);
    set_cpl(0, 3'd0, 64'h300, status_t'(5'h00));
    tick(); cpl_valid_i = '0;
    chk("t3_head_valid", 64'(out_valid_o), 64'd1);
    out_ready_i = 1'b1;
    issue_valid_i = 1'b1;
    issue_tag_i = 4'hE;
    chk("t3_no_bypass", 64'(issue_ready_o), 64'd0);
    tick();
    out_ready_i = 1'b0;
    chk("t3_ready_after_pop", 64'(issue_ready_o), 64'd1);
    chk("t3_wrap_id", 64'(issue_id_o), 64'd0);
    sb.push_back('{result: 64'h3E0, status: status_t'(5'h00), tag: 4'hE});
    exp_tail++;
    tick();
    issue_valid_i = 1'b0;
    chk("t3_refull", 64'(issue_ready_o), 64'd0);
    for (int p = 0; p < 4; p++) set_cpl(p, IDW'(p + 1), 64'h301 + 64'(p), status_t'(5'h00));
    tick(); cpl_valid_i = '0;
    for (int p = 0; p < 3; p++) set_cpl(p, IDW'(p + 5), 64'h305 + 64'(p), status_t'(5'h00));
    set_cpl(3, 3'd0, 64'h3E0, status_t'(5'h00));
    tick(); cpl_valid_i = '0;
    out_ready_i = 1'b1;
    wait_pops("t3_pops", base + 9, 30);
    chk("t3_idle", 64'(busy_o), 64'd0);

    // 4: four ports complete at once, stall three cycles, then drain back to back
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ids[i] = exp_tail;
      issue(TW'(i + 8), 64'h40 + 64'(i), status_t'(5'(i)));
    end
    for (int p = 0; p < 4; p++) set_cpl(p, ids[3-p], 64'h40 + 64'(3-p), status_t'(5'(3-p)));
    tick(); cpl_valid_i = '0;
    for (int k = 0; k < 3; k++) begin
      chk("t4_stall_valid", 64'(out_valid_o), 64'd1);
      chk("t4_stall_result", result_o, 64'h40);
      chk("t4_stall_tag", 64'(tag_o), 64'h8);
      tick();
    end
    base = n_pop;
    out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("t4_back_to_back", 64'(n_pop), 64'(base + 4));
    chk("t4_idle", 64'(busy_o), 64'd0);

    // 5: flush wins over a same-cycle completion; a later stale completion flags err
    reset_dut();
    for (int i = 0; i < 3; i++) issue(TW'(i + 5), 64'h50 + 64'(i), status_t'(5'h00));
    flush_i = 1'b1;
    set_cpl(0, 3'd0, 64'h50, status_t'(5'h00));
    tick();
    flush_i = 1'b0;
    cpl_valid_i = '0;
    sb.delete();
    exp_tail = '0;
    chk("t5_busy", 64'(busy_o), 64'd0);
    chk("t5_out_valid", 64'(out_valid_o), 64'd0);
    chk("t5_issue_ready", 64'(issue_ready_o), 64'd1);
    chk("t5_issue_id", 64'(issue_id_o), 64'd0);
    chk("t5_err_clean", 64'(err_o), 64'd0);
    set_cpl(0, 3'd1, 64'h51, status_t'(5'h00));
    tick(); cpl_valid_i = '0;
    chk("t5_stale_err", 64'(err_o), 64'd1);
    chk("t5_stale_dropped", 64'(out_valid_o), 64'd0);
    tick();
    chk("t5_err_sticky", 64'(err_o), 64'd1);
    reset_dut();
    chk("t5_err_reset", 64'(err_o), 64'd0);

    // 6: two ports hit one id, lowest port wins and err stays set
    base = n_pop;
    out_ready_i = 1'b0;
    issue(4'h9, 64'h600, status_t'(5'h01));
    set_cpl(0, 3'd0, 64'h600, status_t'(5'h01));
    set_cpl(2, 3'd0, 64'h6FF, status_t'(5'h1E));
    tick(); cpl_valid_i = '0;
    chk("t6_err", 64'(err_o), 64'd1);
    chk("t6_valid", 64'(out_valid_o), 64'd1);
    chk("t6_port0_wins", result_o, 64'h600);
    out_ready_i = 1'b1;
    wait_pops("t6_pops", base + 1, 5);
    tick(); tick(); tick();
    chk("t6_err_sticky", 64'(err_o), 64'd1);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
